shared_reg_arbiter: RTL and testbench
=====================================

Name: shared_reg_arbiter

Overview:
Round-robin arbiter that shares one WIDTH-bit enabled register bank (D flip-flops with enable) among NUM_REQ requesters. It grants one requester at a time and steers that requester's write data onto the bank's d/enable pins. An optional lock holds the grant across consecutive writes, bounded by a tenure timeout. It sits between the requesting blocks and the shared register bank.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 8, data width of the shared register
MAX_HOLD, 4, maximum consecutive grant cycles (tenure) for one owner (>=2)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous, active-low reset
i_req  input  NUM_REQ  per-requester write request
i_lock  input  NUM_REQ  per-requester request to keep the grant after the current write
i_wdata  input  NUM_REQ*WIDTH  packed write data; requester k uses bits [k*WIDTH +: WIDTH]
o_gnt  output  NUM_REQ  one-hot grant, all zero when idle
o_owner  output  clog2(NUM_REQ)  index of the granted requester; 0 when idle
o_reg_en  output  1  enable to the shared register bank
o_reg_d  output  WIDTH  data to the shared register bank
o_busy  output  1  high whenever the state is not IDLE
o_timeout  output  1  one-cycle pulse on the forced-release cycle

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - state=IDLE, ptr=0, owner=0, hold_cnt=0.
  - All outputs are 0 immediately, including o_gnt and o_reg_en mid-tenure. No write occurs.
- States: IDLE, GRANT, LOCKED. State, owner, ptr and hold_cnt are registered.
- Arbitration (pick):
  - Search i_req & mask starting at index ptr, ascending and wrapping.
  - The first set bit wins.
  - mask is all-ones from IDLE; the current owner's bit is cleared when picking at the end of a tenure.
- IDLE:
  - If any i_req is set, pick a winner. Next cycle: GRANT, owner=winner, hold_cnt=1.
  - Request-to-grant latency is 1 cycle.
- GRANT / LOCKED, each cycle:
  - o_gnt=onehot(owner).
  - o_reg_en=i_req[owner] (combinational); o_reg_d=i_wdata[owner]. The bank captures on that cycle's closing edge.
  - o_reg_d is 0 when o_reg_en=0.
- Tenure end. The tenure ends when any of the following holds:
  - i_req[owner]=0, or
  - i_lock[owner]=0, or
  - hold_cnt==MAX_HOLD. If i_lock[owner] and i_req[owner] are still high in this case, o_timeout=1 in this cycle.
- At tenure end:
  - ptr <= owner+1 mod NUM_REQ.
  - Pick with the owner masked. If there is a winner: GRANT with the new owner and hold_cnt=1, back-to-back with no idle cycle. Otherwise: IDLE.
  - An owner that is the sole requester is therefore regranted only after one IDLE cycle.
- Otherwise (lock and req held, hold_cnt<MAX_HOLD): LOCKED, hold_cnt+1.
- hold_cnt width is clog2(MAX_HOLD+1) and it never wraps.
- Requests from non-owners have no effect during a tenure.
- i_lock is ignored for non-owners.
- Late i_req/i_lock changes from the owner take effect in the same cycle (combinational decision).

Decomposition:
- Package shared_reg_arb_pkg holds:
  - state encoding: IDLE=2'b00, GRANT=2'b01, LOCKED=2'b10;
  - the clog2-based width helper constant function.
- Sub-module rr_pick (combinational):
  - inputs: req, mask, ptr;
  - outputs: onehot, index, valid;
  - instantiated once in shared_reg_arbiter.

Test Plan:
(NUM_REQ=4, WIDTH=8, MAX_HOLD=4)
1. Reset: i_rst_n=0 with i_req=4'b1111 -> all outputs 0. Release with i_req=0 -> o_busy stays 0.
2. Single request: i_req=4'b0010, i_lock=0, data1=8'hA5 -> next cycle o_gnt=0010, o_owner=1, o_reg_en=1, o_reg_d=A5. Then one IDLE cycle, then regrant.
3. Full contention, no lock, i_req=4'b1111 from reset -> o_gnt = 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with o_reg_en=1 every cycle.
4. Timeout: i_req=4'b0101, i_lock=4'b0001 -> o_gnt=0001 for 4 cycles with o_timeout=1 on the 4th cycle only, then o_gnt=0100.
5. Early unlock: same as test 4, but i_lock[0] drops in tenure cycle 2 -> o_gnt=0100 in cycle 3; o_timeout never asserts.
6. Reset mid-LOCKED: drop i_rst_n between clock edges -> o_gnt/o_reg_en go to 0 before the next edge. After release with i_req=4'b1111, the first grant is 0001 (ptr=0).

Source files
------------

// File: rtl/shared_reg_arb_pkg.sv
// Shared types and helpers for the shared register-bank arbiter.
//   arb_state_e : arbiter state encoding
//   idx_width() : bit width needed to index n items (minimum 1)
package shared_reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT  = 2'b01,
        LOCKED = 2'b10
    } arb_state_e;

    // Width of an index into n items, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of (req & mask) searching
// upward from ptr with wrap-around.
//   req    : candidate requests
//   mask   : per-bit qualifier applied to req
//   ptr    : search start index
//   onehot : one-hot winner (zero when none)
//   index  : winner index (zero when none)
//   valid  : a winner exists
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] index,
    output logic          valid
);

    logic [N-1:0] cand;

    assign cand = req & mask;

    // Walk candidates from ptr; the first hit locks out later ones.
    always_comb begin
        logic [IW-1:0] k;
        k      = '0;
        onehot = '0;
        index  = '0;
        valid  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            k = IW'((32'(ptr) + i) % N);
            if (!valid && cand[k]) begin
                valid     = 1'b1;
                index     = k;
                onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one enabled register bank among requesters,
// with an optional grant lock bounded by a tenure limit.
//   i_clk, i_rst_n : clock (rising edge), async active-low reset
//   i_req          : per-requester write request
//   i_lock         : per-requester request to keep the grant
//   i_wdata        : packed write data, requester k at [k*WIDTH +: WIDTH]
//   o_gnt          : one-hot grant (zero when idle)
//   o_owner        : granted requester index (zero when idle)
//   o_reg_en       : bank enable, follows the owner's request this cycle
//   o_reg_d        : bank data (zero when not enabled)
//   o_busy         : state is not IDLE
//   o_timeout      : pulse on a forced release at the tenure limit
module shared_reg_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic [NUM_REQ-1:0]                 i_req,
    input  logic [NUM_REQ-1:0]                 i_lock,
    input  logic [NUM_REQ*WIDTH-1:0]           i_wdata,
    output logic [NUM_REQ-1:0]                 o_gnt,
    output logic [idx_width(NUM_REQ)-1:0]      o_owner,
    output logic                               o_reg_en,
    output logic [WIDTH-1:0]                   o_reg_d,
    output logic                               o_busy,
    output logic                               o_timeout
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);
    localparam int unsigned CNT_W = idx_width(MAX_HOLD + 1);

    arb_state_e         state_q,    state_d;
    logic [IDX_W-1:0]   owner_q,    owner_d;
    logic [IDX_W-1:0]   ptr_q,      ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] gnt_q,      gnt_d;

    logic               busy;
    logic               own_req;
    logic               own_lock;
    logic               at_max;
    logic               tenure_end;
    logic [IDX_W-1:0]   ptr_next;
    logic [NUM_REQ-1:0] pick_mask;
    logic [IDX_W-1:0]   pick_ptr;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    assign busy       = (state_q != IDLE);
    assign own_req    = |(i_req  & gnt_q);
    assign own_lock   = |(i_lock & gnt_q);
    assign at_max     = (hold_cnt_q == CNT_W'(MAX_HOLD));
    assign tenure_end = busy && (!own_req || !own_lock || at_max);
    assign ptr_next   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    // During a tenure the search starts after the owner and skips it.
    assign pick_mask  = busy ? ~gnt_q : '1;
    assign pick_ptr   = busy ? ptr_next : ptr_q;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_pick (
        .req    (i_req),
        .mask   (pick_mask),
        .ptr    (pick_ptr),
        .onehot (pick_oh),
        .index  (pick_idx),
        .valid  (pick_valid)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
        end
    end

    // Next state and bank-facing outputs
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        o_reg_en   = 1'b0;
        o_reg_d    = '0;
        o_timeout  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = GRANT;
                    owner_d    = pick_idx;
                    gnt_d      = pick_oh;
                    hold_cnt_d = CNT_W'(1);
                end
            end
            GRANT, LOCKED: begin
                o_reg_en  = own_req;
                o_timeout = at_max && own_req && own_lock;
                if (own_req) begin
                    o_reg_d = i_wdata[32'(owner_q)*WIDTH +: WIDTH];
                end
                if (tenure_end) begin
                    ptr_d = ptr_next;
                    if (pick_valid) begin
                        state_d    = GRANT;
                        owner_d    = pick_idx;
                        gnt_d      = pick_oh;
                        hold_cnt_d = CNT_W'(1);
                    end else begin
                        state_d    = IDLE;
                        owner_d    = '0;
                        gnt_d      = '0;
                        hold_cnt_d = '0;
                    end
                end else begin
                    state_d    = LOCKED;
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                owner_d    = '0;
                gnt_d      = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    assign o_gnt   = gnt_q;
    assign o_owner = owner_q;
    assign o_busy  = busy;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter (NUM_REQ=4, WIDTH=8, MAX_HOLD=4).
module tb_shared_reg_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned MH = 4;

    logic          clk;
    logic          rst_n;
    logic [NR-1:0] req;
    logic [NR-1:0] lock;
    logic [NR*W-1:0] wdata;
    logic [NR-1:0] gnt;
    logic [1:0]    owner;
    logic          reg_en;
    logic [W-1:0]  reg_d;
    logic          busy;
    logic          timeout;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    shared_reg_arbiter #(
        .NUM_REQ  (NR),
        .WIDTH    (W),
        .MAX_HOLD (MH)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_lock    (lock),
        .i_wdata   (wdata),
        .o_gnt     (gnt),
        .o_owner   (owner),
        .o_reg_en  (reg_en),
        .o_reg_d   (reg_d),
        .o_busy    (busy),
        .o_timeout (timeout)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       en;
        logic [7:0] d;
        logic       busy;
        logic       timeout;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_hold;

    obs_t got;
    obs_t want;

    function automatic obs_t observe();
        obs_t o;
        o.gnt     = gnt;
        o.owner   = owner;
        o.en      = reg_en;
        o.d       = reg_d;
        o.busy    = busy;
        o.timeout = timeout;
        return o;
    endfunction

    function automatic int find_first(input logic [3:0] r, input int start);
        int k;
        for (int j = 0; j < 4; j++) begin
            k = (start + j) % 4;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    function automatic obs_t model_out(input logic [3:0] r, input logic [3:0] l,
                                       input logic [31:0] wd);
        obs_t o;
        o = '0;
        if (m_busy) begin
            o.gnt     = 4'b0001 << m_owner;
            o.owner   = 2'(m_owner);
            o.busy    = 1'b1;
            o.en      = r[m_owner];
            if (o.en) o.d = wd[m_owner*8 +: 8];
            o.timeout = (m_hold == MH) && r[m_owner] && l[m_owner];
        end
        return o;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic [3:0] l);
        int w;
        logic [3:0] others;
        if (!m_busy) begin
            w = find_first(r, m_ptr);
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_owner = w;
                m_hold  = 1;
            end
        end else if (!r[m_owner] || !l[m_owner] || m_hold == MH) begin
            m_ptr  = (m_owner + 1) % 4;
            others = r & ~(4'b0001 << m_owner);
            w      = find_first(others, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_hold  = 1;
            end else begin
                m_busy  = 1'b0;
                m_owner = 0;
                m_hold  = 0;
            end
        end else begin
            m_hold++;
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_hold  = 0;
    endtask

    // Drive one cycle of stimulus and queue the model's expectation for it.
    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [31:0] wd);
        @(negedge clk);
        req   = r;
        lock  = l;
        wdata = wd;
        exp_q.push_back(model_out(r, l, wd));
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        wdata = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        lock  = 4'b1111;
        wdata = 32'hFFFF_FFFF;
        model_reset();
        #2;
        n_checks++;
        if (observe() !== obs_t'(0)) $display("FAIL reset_early got=%h want=0", observe());
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if (observe() !== obs_t'(0)) $display("FAIL reset_held got=%h want=0", observe());
        else n_pass++;
        req   = '0;
        lock  = '0;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(4'b0000, 4'b0000, 32'h0);
            got  = observe();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want || busy !== 1'b0)
                $display("FAIL reset_release cyc%0d got=%h want=%h", c, got, want);
            else n_pass++;
            model_step(req, lock);
        end
    endtask

    task automatic test_single();
        logic [3:0] gnt_tbl [0:4];
        logic [7:0] d_tbl   [0:4];
        gnt_tbl = '{4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
        d_tbl   = '{8'h00,   8'hA5,   8'h00,   8'hA5,   8'h00};
        for (int c = 0; c < 5; c++) begin
            drive(4'b0010, 4'b0000, 32'h0000_A500);
            got  = observe();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL single cyc%0d got=%h want=%h", c, got, want);
            else n_pass++;
            n_checks++;
            if (gnt !== gnt_tbl[c] || reg_d !== d_tbl[c] || reg_en !== gnt_tbl[c][1])
                $display("FAIL single_tbl cyc%0d got gnt=%b d=%h en=%b want gnt=%b d=%h",
                         c, gnt, reg_d, reg_en, gnt_tbl[c], d_tbl[c]);
            else n_pass++;
            model_step(req, lock);
        end
    endtask

    task automatic test_full_contention();
        logic [3:0] gnt_tbl [0:5];
        gnt_tbl = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            drive(4'b1111, 4'b0000, $urandom());
            got  = observe();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL full cyc%0d got=%h want=%h", c, got, want);
            else n_pass++;
            n_checks++;
            if (gnt !== gnt_tbl[c] || reg_en !== (c != 0))
                $display("FAIL full_tbl cyc%0d got gnt=%b en=%b want gnt=%b", c, gnt, reg_en, gnt_tbl[c]);
            else n_pass++;
            model_step(req, lock);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] gnt_tbl [0:6];
        logic       to_tbl  [0:6];
        gnt_tbl = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0001};
        to_tbl  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            drive(4'b0101, 4'b0001, $urandom());
            got  = observe();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL timeout cyc%0d got=%h want=%h", c, got, want);
            else n_pass++;
            n_checks++;
            if (gnt !== gnt_tbl[c] || timeout !== to_tbl[c])
                $display("FAIL timeout_tbl cyc%0d got gnt=%b to=%b want gnt=%b to=%b",
                         c, gnt, timeout, gnt_tbl[c], to_tbl[c]);
            else n_pass++;
            model_step(req, lock);
        end
    endtask

    task automatic test_early_unlock();
        logic [3:0] gnt_tbl  [0:4];
        logic [3:0] lock_tbl [0:4];
        gnt_tbl  = '{4'b0000, 4'b0001, 4'b0001, 4'b0100, 4'b0001};
        lock_tbl = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            drive(4'b0101, lock_tbl[c], $urandom());
            got  = observe();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL unlock cyc%0d got=%h want=%h", c, got, want);
            else n_pass++;
            n_checks++;
            if (gnt !== gnt_tbl[c] || timeout !== 1'b0)
                $display("FAIL unlock_tbl cyc%0d got gnt=%b to=%b want gnt=%b to=0",
                         c, gnt, timeout, gnt_tbl[c]);
            else n_pass++;
            model_step(req, lock);
        end
    endtask

    task automatic test_reset_mid_locked();
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            drive(4'b0101, 4'b0001, 32'h0033_0011);
            got  = observe();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL midrst_pre cyc%0d got=%h want=%h", c, got, want);
            else n_pass++;
            model_step(req, lock);
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (gnt !== 4'b0001 || reg_en !== 1'b1 || reg_d !== 8'h11)
            $display("FAIL midrst_locked got gnt=%b en=%b d=%h want gnt=0001 en=1 d=11", gnt, reg_en, reg_d);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (observe() !== obs_t'(0)) $display("FAIL midrst_async got=%h want=0", observe());
        else n_pass++;
        model_reset();
        @(negedge clk);
        req  = '0;
        lock = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive(4'b1111, 4'b0000, $urandom());
            got  = observe();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want || gnt !== ((c == 1) ? 4'b0001 : 4'b0000))
                $display("FAIL midrst_post cyc%0d got=%h want=%h", c, got, want);
            else n_pass++;
            model_step(req, lock);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic [3:0] l;
        r = 4'b0000;
        l = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) l = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            drive(r, l, $urandom());
            got  = observe();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL random cyc%0d got=%h want=%h", c, got, want);
            else n_pass++;
            model_step(req, lock);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_contention();
        test_timeout();
        test_early_unlock();
        test_reset_mid_locked();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
